// File: rtl/simple_cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller driving cpu_top from a synchronous instruction memory.
// Optional latched ALU flags are built only when SEQ_FLAGS_EN is defined.
module simple_cpu_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_cout,
    output logic                   reg_write_enable,
    output logic [2:0]             reg_read_addr1,
    output logic [2:0]             reg_read_addr2,
    output logic [2:0]             reg_write_addr,
    output logic [DATA_WIDTH-1:0]  reg_write_data,
    output logic                   b_source_select,
    output logic                   alu_cin,
    output logic                   alu_mode,
    output logic [3:0]             alu_sel,
    output logic [DATA_WIDTH-1:0]  alu_b_imm,
    output logic                   busy,
    output logic                   done,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   flag_carry,
    output logic                   flag_zero
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, DONE} state_e;
    typedef enum logic [1:0] {OP_RR, OP_RI, OP_LDI, OP_HALT} opcode_e;

    state_e                  state_q;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    we_q;

    opcode_e                 op;
    opcode_e                 fetched_op;
    logic                    ctrl_active;
    logic [DATA_WIDTH-1:0]   imm_ext;

    assign op          = opcode_e'(instr_q[31:30]);
    assign fetched_op  = opcode_e'(imem_data[31:30]);
    assign ctrl_active = (state_q == EXEC) || (state_q == WB);
    assign imm_ext     = DATA_WIDTH'(instr_q[15:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pc_q    <= start_pc;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: state_q <= DECODE;
                DECODE: begin
                    instr_q <= imem_data;
                    if (fetched_op == OP_HALT) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= (op == OP_LDI) ? imm_ext : alu_result;
                    we_q     <= 1'b1;
                    state_q  <= WB;
                end
                WB: begin
                    // result register doubles as the write-data driver, so it is cleared once the write is issued
                    we_q     <= 1'b0;
                    result_q <= '0;
                    pc_q     <= pc_q + PC_WIDTH'(1);
                    state_q  <= FETCH;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_addr        = pc_q;
    assign pc               = pc_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign reg_write_enable = we_q;
    assign reg_write_data   = result_q;

    assign reg_read_addr1  = ctrl_active ? instr_q[20:18] : '0;
    assign reg_read_addr2  = (ctrl_active && op == OP_RR) ? instr_q[2:0] : '0;
    assign reg_write_addr  = ctrl_active ? instr_q[23:21] : '0;
    assign b_source_select = ctrl_active && (op == OP_RI);
    assign alu_cin         = ctrl_active & instr_q[24];
    assign alu_mode        = ctrl_active & instr_q[25];
    assign alu_sel         = ctrl_active ? instr_q[29:26] : '0;
    assign alu_b_imm       = ctrl_active ? imm_ext : '0;

`ifdef SEQ_FLAGS_EN
    logic flag_carry_q;
    logic flag_zero_q;
    logic unused_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
        end else if (state_q == IDLE && start) begin
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
        end else if (state_q == EXEC && (op == OP_RR || op == OP_RI)) begin
            flag_carry_q <= alu_cout;
            flag_zero_q  <= (alu_result == '0);
        end
    end

    assign flag_carry  = flag_carry_q;
    assign flag_zero   = flag_zero_q;
    assign unused_bits = ^instr_q[17:16];
`else
    logic unused_bits;

    assign flag_carry  = 1'b0;
    assign flag_zero   = 1'b0;
    assign unused_bits = ^{instr_q[17:16], alu_cout};
`endif

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Bench for simple_cpu_sequencer: instruction memory, register file and ALU stand-ins around the DUT,
// with an instruction-level reference model predicting per-cycle outputs.
module tb_simple_cpu_sequencer;

    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [PW-1:0] start_pc = '0;
    logic [PW-1:0] imem_addr, pc;
    logic [31:0]   imem_data;
    logic [DW-1:0] alu_result, reg_write_data, alu_b_imm;
    logic          alu_cout, reg_write_enable, b_source_select, alu_cin, alu_mode;
    logic          busy, done, flag_carry, flag_zero;
    logic [2:0]    reg_read_addr1, reg_read_addr2, reg_write_addr;
    logic [3:0]    alu_sel;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] mem [256];
    logic [15:0] rf [8] = '{default: 16'h0};
    logic [15:0] mref [8];
    logic [16:0] alu_bus;

    simple_cpu_sequencer #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .INSTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .reg_write_enable(reg_write_enable), .reg_read_addr1(reg_read_addr1),
        .reg_read_addr2(reg_read_addr2), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .b_source_select(b_source_select),
        .alu_cin(alu_cin), .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_b_imm(alu_b_imm),
        .busy(busy), .done(done), .pc(pc), .flag_carry(flag_carry), .flag_zero(flag_zero)
    );

    // ALU stand-in: sel=1001/mode=0 is A plus B (cin=1 means no carry-in, 74181 style)
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] sel, input logic mode, input logic cin);
        if (mode) return {1'b0, a ^ b ^ {12'h0, sel}};
        if (sel == 4'b1001) return {1'b0, a} + {1'b0, b} + {16'h0, ~cin};
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [3:0] sel, input logic mode,
                                        input logic cin, input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [1:0] rsv, input logic [15:0] imm);
        return {op, sel, mode, cin, rd, ra, rsv, imm};
    endfunction

    function automatic logic [63:0] ctrl_vec(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                             input logic [2:0] ra1, input logic [2:0] ra2, input logic bsel,
                                             input logic cin, input logic mode, input logic [3:0] sel,
                                             input logic [15:0] bimm);
        return {15'h0, we, wa, wd, ra1, ra2, bsel, cin, mode, sel, bimm};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= mem[imem_addr];
    always @(posedge clk) if (reg_write_enable) rf[reg_write_addr] <= reg_write_data;

    assign alu_bus    = alu_f(rf[reg_read_addr1], b_source_select ? alu_b_imm : rf[reg_read_addr2],
                              alu_sel, alu_mode, alu_cin);
    assign alu_result = alu_bus[15:0];
    assign alu_cout   = alu_bus[16];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Executes the program at spc in the model, then checks the DUT cycle by cycle
    task automatic run_prog(input logic [7:0] spc, input int inject_k);
        logic [31:0] w [$];
        logic [15:0] v [$];
        logic        fc [$];
        logic        fz [$];
        logic        fupd [$];
        logic [7:0]  p;
        logic [31:0] iw, cw;
        logic [15:0] a, b, res;
        logic [16:0] ab;
        logic [7:0]  epc;
        logic        ef_c, ef_z, ebusy, edone, in_ex;
        logic [63:0] exp_v, act_v;
        logic [1:0]  eflags;
        int          n, i, ph;

        p = spc;
        n = 0;
        while (n < 64) begin
            iw = mem[p];
            if (iw[31:30] == 2'b11) break;
            a   = mref[iw[20:18]];
            b   = (iw[31:30] == 2'b01) ? iw[15:0] : mref[iw[2:0]];
            ab  = alu_f(a, b, iw[29:26], iw[25], iw[24]);
            res = (iw[31:30] == 2'b10) ? iw[15:0] : ab[15:0];
            mref[iw[23:21]] = res;
            w.push_back(iw);
            v.push_back(res);
            fupd.push_back(iw[31:30] != 2'b10);
            fc.push_back(ab[16]);
            fz.push_back(ab[15:0] == 16'h0);
            p = p + 8'd1;
            n++;
        end

        ef_c = 1'b0;
        ef_z = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        start_pc = spc;
        @(posedge clk);
        #1;
        start    = 1'b0;
        start_pc = 8'($urandom);

        for (int k = 0; k <= 4 * n + 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (k < 4 * n) begin
                i  = k / 4;
                ph = k % 4;
            end else begin
                i  = n;
                ph = 4 + (k - 4 * n);
            end
            epc   = spc + 8'(i);
            ebusy = (ph <= 5);
            edone = (ph == 6);
            in_ex = (ph == 2) || (ph == 3);
            if (ph == 3 && fupd[i]) begin
                ef_c = fc[i];
                ef_z = fz[i];
            end
            cw    = in_ex ? w[i] : 32'h0;
            exp_v = in_ex ? ctrl_vec(ph == 3, cw[23:21], (ph == 3) ? v[i] : 16'h0, cw[20:18],
                                     (cw[31:30] == 2'b00) ? cw[2:0] : 3'h0, cw[31:30] == 2'b01,
                                     cw[24], cw[25], cw[29:26], cw[15:0])
                          : 64'h0;
            act_v = ctrl_vec(reg_write_enable, reg_write_addr, (ph == 2) ? 16'h0 : reg_write_data,
                             reg_read_addr1, (in_ex && cw[31:30] != 2'b00) ? 3'h0 : reg_read_addr2,
                             b_source_select, alu_cin, alu_mode, alu_sel, alu_b_imm);
`ifdef SEQ_FLAGS_EN
            eflags = {ef_c, ef_z};
`else
            eflags = 2'b00;
`endif
            check($sformatf("pc@%02h+%0d", spc, k), {48'h0, imem_addr, pc}, {48'h0, epc, epc});
            check($sformatf("busy@%02h+%0d", spc, k), 64'(busy), 64'(ebusy));
            check($sformatf("done@%02h+%0d", spc, k), 64'(done), 64'(edone));
            check($sformatf("ctrl@%02h+%0d", spc, k), act_v, exp_v);
            check($sformatf("flags@%02h+%0d", spc, k), {62'h0, flag_carry, flag_zero}, {62'h0, eflags});
            if (k == inject_k) begin
                start    = 1'b1;
                start_pc = 8'h40;
            end
        end
    endtask

    task automatic reset_mid_op();
        mem[8'h20] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd5, 3'd0, 2'b00, 16'h1234);
        mem[8'h21] = enc(2'b11, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0);
        @(negedge clk);
        start    = 1'b1;
        start_pc = 8'h20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_pre_exec", {61'h0, busy, reg_write_addr}, {61'h0, 1'b1, 3'd5});
        #2;
        reset = 1'b0;
        #1;
        check("rst_ctrl_zero", ctrl_vec(reg_write_enable, reg_write_addr, reg_write_data, reg_read_addr1,
                                        reg_read_addr2, b_source_select, alu_cin, alu_mode, alu_sel,
                                        alu_b_imm), 64'h0);
        check("rst_status_zero", {44'h0, busy, done, imem_addr, pc, flag_carry, flag_zero}, 64'h0);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                start    = 1'b1;
                start_pc = 8'h33;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("rst_hold%0d", c), {55'h0, busy, reg_write_enable, pc}, 64'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_idle%0d", c), {55'h0, busy, reg_write_enable, pc}, 64'h0);
        end
        check("rst_no_write_r5", 64'(rf[5]), 64'(mref[5]));
    endtask

    initial begin
        logic [7:0] spc;
        int         n, op, inj;

        foreach (mem[j]) mem[j] = enc(2'b11, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0);
        foreach (mref[j]) mref[j] = 16'h0;

        #12;
        check("reset_ctrl", ctrl_vec(reg_write_enable, reg_write_addr, reg_write_data, reg_read_addr1,
                                     reg_read_addr2, b_source_select, alu_cin, alu_mode, alu_sel,
                                     alu_b_imm), 64'h0);
        check("reset_status", {44'h0, busy, done, imem_addr, pc, flag_carry, flag_zero}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'h0);

        // LDI r1,5 ; LDI r2,3 ; HALT
        mem[0] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd1, 3'd0, 2'b00, 16'h0005);
        mem[1] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd2, 3'd0, 2'b00, 16'h0003);
        run_prog(8'h00, -1);

        // r3 = r1 plus r2
        mem[8'h10] = enc(2'b00, 4'b1001, 1'b0, 1'b1, 3'd3, 3'd1, 2'b00, 16'h0002);
        run_prog(8'h10, -1);
        check("r3_sum", 64'(rf[3]), 64'h0008);

        // r1 = FFFF ; r4 = r1 plus 1
        mem[8'h30] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd1, 3'd0, 2'b00, 16'hFFFF);
        mem[8'h31] = enc(2'b01, 4'b1001, 1'b0, 1'b1, 3'd4, 3'd1, 2'b00, 16'h0001);
        run_prog(8'h30, -1);
        check("r4_wrap", 64'(rf[4]), 64'h0000);

        // pc wrap: LDI at FF, HALT at 00
        mem[8'hFF] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd6, 3'd0, 2'b00, 16'hBEEF);
        mem[8'h00] = enc(2'b11, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0);
        run_prog(8'hFF, -1);

        // start pulsed during WB of the first instruction must be ignored
        mem[8'h50] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd7, 3'd0, 2'b00, 16'h1111);
        mem[8'h51] = enc(2'b10, 4'h0, 1'b0, 1'b0, 3'd2, 3'd0, 2'b00, 16'h2222);
        run_prog(8'h50, 3);

        reset_mid_op();

        for (int r = 0; r < 10; r++) begin
            spc = 8'($urandom);
            n   = int'($urandom_range(1, 5));
            for (int q = 0; q < n; q++) begin
                op = int'($urandom_range(0, 2));
                mem[spc + 8'(q)] = enc(2'(op), 4'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                                       3'($urandom), 2'($urandom), 16'($urandom));
            end
            mem[spc + 8'(n)] = enc(2'b11, 4'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                                   3'($urandom), 2'($urandom), 16'($urandom));
            inj = (r % 2 == 0) ? -1 : int'($urandom_range(1, 4 * n + 1));
            run_prog(spc, inj);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
